i2s_dac_transmitter: RTL and testbench

I2S_DAC_TRANSMITTER -- requirements
Module: i2s_dac_transmitter

---
 rtl/i2s_dac_transmitter.sv | 159 +++++++++++++++
 tb/tb_i2s_dac_transmitter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_dac_transmitter.sv
// i2s_dac_transmitter
//   Stereo I2S transmitter for an audio DAC. Sample pairs are pushed into a
//   small FIFO in the CLOCK_50 domain and serialised MSB-first onto
//   AUD_DACDAT, timed by the codec's AUD_BCLK / AUD_DACLRCK. Both codec
//   clocks are asynchronous and are oversampled by CLOCK_50.
//
// Ports
//   CLOCK_50         system clock, all state updates on its rising edge
//   reset            synchronous, active-high reset
//   write            push request for one stereo pair
//   writedata_left   left sample (two's complement)
//   writedata_right  right sample (two's complement)
//   write_ready      FIFO can accept a pair this cycle
//   AUD_BCLK         codec bit clock (async)
//   AUD_DACLRCK      codec frame clock (async), low = left, high = right
//   AUD_DACDAT       serial data to the codec
//   underflow        sticky: a frame started with the FIFO empty
//   fifo_level       number of stored pairs
module i2s_dac_transmitter #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          write,
    input  logic [DATA_WIDTH-1:0]         writedata_left,
    input  logic [DATA_WIDTH-1:0]         writedata_right,
    output logic                          write_ready,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_DACLRCK,
    output logic                          AUD_DACDAT,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BITS = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } state_t;

    state_t state;

    logic bclk_s1, bclk_s2, bclk_d;
    logic lrck_s1, lrck_s2, lrck_d;
    logic bclk_fall, lrck_fall, lrck_rise;

    logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;

    logic push, pop_req, pop_ok, load_right;

    logic [DATA_WIDTH-1:0] shift_reg, hold_reg;
    logic [CW-1:0]         bit_cnt;

    // Two-flop synchronisers plus one delay flop for edge detection.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_d  <= 1'b0;
            lrck_s1 <= 1'b0;
            lrck_s2 <= 1'b0;
            lrck_d  <= 1'b0;
        end else begin
            bclk_s1 <= AUD_BCLK;
            bclk_s2 <= bclk_s1;
            bclk_d  <= bclk_s2;
            lrck_s1 <= AUD_DACLRCK;
            lrck_s2 <= lrck_s1;
            lrck_d  <= lrck_s2;
        end
    end

    assign bclk_fall = bclk_d & ~bclk_s2;
    assign lrck_fall = lrck_d & ~lrck_s2;
    assign lrck_rise = ~lrck_d & lrck_s2;

    assign write_ready = (fifo_level < FULL);
    assign push        = write & write_ready;

    // A falling LRCK starts a new frame from IDLE or RIGHT; it is ignored in LEFT.
    assign pop_req    = lrck_fall & (state != LEFT);
    assign pop_ok     = pop_req & (fifo_level != '0);
    assign load_right = lrck_rise & (state == LEFT);

    // FIFO bookkeeping. An empty-FIFO pop is an underflow and does not move
    // rd_ptr, so a push in the same cycle is simply stored.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop_ok})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_l[wr_ptr] <= writedata_left;
            mem_r[wr_ptr] <= writedata_right;
        end
    end

    // Frame FSM and serialiser. A word load drives a 0 for one BCLK, which
    // produces the I2S one-bit delay after each LRCK edge; a load always wins
    // over a coincident BCLK fall.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= '0;
            hold_reg   <= '0;
            bit_cnt    <= '0;
            AUD_DACDAT <= 1'b0;
            underflow  <= 1'b0;
        end else if (pop_req) begin
            state      <= LEFT;
            bit_cnt    <= BITS;
            AUD_DACDAT <= 1'b0;
            if (pop_ok) begin
                shift_reg <= mem_l[rd_ptr];
                hold_reg  <= mem_r[rd_ptr];
            end else begin
                shift_reg <= '0;
                hold_reg  <= '0;
                underflow <= 1'b1;
            end
        end else if (load_right) begin
            state      <= RIGHT;
            shift_reg  <= hold_reg;
            bit_cnt    <= BITS;
            AUD_DACDAT <= 1'b0;
        end else if (bclk_fall) begin
            if (bit_cnt != '0) begin
                AUD_DACDAT <= shift_reg[DATA_WIDTH-1];
                shift_reg  <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                bit_cnt    <= bit_cnt - 1'b1;
            end else begin
                AUD_DACDAT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// tb_i2s_dac_transmitter
//   Self-checking bench for i2s_dac_transmitter. The codec clocks are
//   generated slowly relative to CLOCK_50 (one BCLK = 2*H system clocks,
//   32 BCLKs per channel slot). The reference model is a queue of pairs:
//   every LRCK fall takes the head pair (or zeros plus underflow when empty)
//   and each slot is expected to read {0, word, zero padding} on BCLK rises.
module tb_i2s_dac_transmitter;

    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int H     = 6;
    localparam int SLOT  = 32;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          write;
    logic [DW-1:0] writedata_left;
    logic [DW-1:0] writedata_right;
    logic          write_ready;
    logic          AUD_BCLK;
    logic          AUD_DACLRCK;
    logic          AUD_DACDAT;
    logic          underflow;
    logic [LW-1:0] fifo_level;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ql[$];
    logic [DW-1:0] qr[$];
    bit            m_under;

    bit mon_on   = 1'b0;
    int over_cnt = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    i2s_dac_transmitter #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .write          (write),
        .writedata_left (writedata_left),
        .writedata_right(writedata_right),
        .write_ready    (write_ready),
        .AUD_BCLK       (AUD_BCLK),
        .AUD_DACLRCK    (AUD_DACLRCK),
        .AUD_DACDAT     (AUD_DACDAT),
        .underflow      (underflow),
        .fifo_level     (fifo_level)
    );

    always @(negedge CLOCK_50)
        if (mon_on && fifo_level > LW'(DEPTH))
            over_cnt++;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic [LW-1:0] exp_level;
        logic          exp_ready;
    } push_vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [SLOT-1:0] slot_bits(input logic [DW-1:0] w);
        return {1'b0, w, {(SLOT-DW-1){1'b0}}};
    endfunction

    // Called at a negedge; holds write for one rising edge.
    task automatic try_push(input logic [DW-1:0] l, input logic [DW-1:0] r);
        write           = 1'b1;
        writedata_left  = l;
        writedata_right = r;
        @(negedge CLOCK_50);
        write = 1'b0;
        if (ql.size() < DEPTH) begin
            ql.push_back(l);
            qr.push_back(r);
        end
        check("push_level", 64'(fifo_level), 64'(ql.size()));
        check("push_ready", 64'(write_ready), 64'(ql.size() < DEPTH));
    endtask

    // One BCLK period starting with the falling edge; returns the data bit
    // present just before the rising edge (where the codec samples it).
    task automatic bclk_cycle(input bit rnd, output logic bit_out);
        AUD_BCLK = 1'b0;
        for (int k = 0; k < H; k++) begin
            if (rnd && k == 1 && $urandom_range(0, 31) == 0)
                try_push(DW'($urandom), DW'($urandom));
            else
                @(negedge CLOCK_50);
        end
        bit_out  = AUD_DACDAT;
        AUD_BCLK = 1'b1;
        repeat (H) @(negedge CLOCK_50);
    endtask

    task automatic idle_bclks(input int n, output logic any_one);
        logic b;
        any_one = 1'b0;
        for (int i = 0; i < n; i++) begin
            bclk_cycle(1'b0, b);
            any_one = any_one | b;
        end
    endtask

    task automatic half(input logic lr, input bit rnd, input logic [DW-1:0] word, input string name);
        logic [SLOT-1:0] got;
        logic            b;
        AUD_DACLRCK = lr;
        for (int i = 0; i < SLOT; i++) begin
            // Pushes stay clear of the LRCK edge so their order against the pop is known.
            bclk_cycle(rnd && i >= 2, b);
            got[SLOT-1-i] = b;
        end
        check(name, 64'(got), 64'(slot_bits(word)));
    endtask

    // Full frame; LRCK must be high on entry. refill models a held write
    // that re-fills the slot freed by the pop.
    task automatic frame(input bit rnd, input bit refill);
        logic [DW-1:0] l, r;
        if (ql.size() == 0) begin
            l = '0;
            r = '0;
            m_under = 1'b1;
        end else begin
            l = ql.pop_front();
            r = qr.pop_front();
        end
        if (refill) begin
            ql.push_back(l);
            qr.push_back(r);
        end
        half(1'b0, rnd, l, "left_word");
        half(1'b1, rnd, r, "right_word");
        check("frame_underflow", 64'(underflow), 64'(m_under));
        check("frame_level", 64'(fifo_level), 64'(ql.size()));
    endtask

    // Starts a frame with a push landing on the same rising edge as the pop:
    // LRCK fall -> two sync flops -> edge flop -> pop on the third edge.
    task automatic coincident_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        logic [DW-1:0]   pl, pr;
        logic [SLOT-1:0] got;
        logic            b;
        if (ql.size() == 0) begin
            pl = '0;
            pr = '0;
            m_under = 1'b1;
        end else begin
            pl = ql.pop_front();
            pr = qr.pop_front();
        end
        ql.push_back(l);
        qr.push_back(r);
        AUD_DACLRCK = 1'b0;
        AUD_BCLK    = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        write           = 1'b1;
        writedata_left  = l;
        writedata_right = r;
        @(negedge CLOCK_50);
        write = 1'b0;
        check("coinc_level", 64'(fifo_level), 64'(ql.size()));
        check("coinc_underflow", 64'(underflow), 64'(m_under));
        repeat (H - 3) @(negedge CLOCK_50);
        got[SLOT-1] = AUD_DACDAT;
        AUD_BCLK    = 1'b1;
        repeat (H) @(negedge CLOCK_50);
        for (int i = 1; i < SLOT; i++) begin
            bclk_cycle(1'b0, b);
            got[SLOT-1-i] = b;
        end
        check("coinc_left", 64'(got), 64'(slot_bits(pl)));
        half(1'b1, 1'b0, pr, "coinc_right");
    endtask

    initial begin
        push_vec_t     vecs[5];
        logic          any_one;
        logic          b;
        logic [DW-1:0] cl, cr;

        reset           = 1'b1;
        write           = 1'b0;
        writedata_left  = '0;
        writedata_right = '0;
        AUD_BCLK        = 1'b0;
        AUD_DACLRCK     = 1'b0;
        m_under         = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_ready", 64'(write_ready), 64'(1));
        check("rst_underflow", 64'(underflow), 64'(0));
        check("rst_dacdat", 64'(AUD_DACDAT), 64'(0));

        // LRCK rises before any fall: no pop, no output.
        try_push(24'h123456, 24'h654321);
        AUD_DACLRCK = 1'b1;
        idle_bclks(4, any_one);
        check("early_rise_silent", 64'(any_one), 64'(0));
        check("early_rise_level", 64'(fifo_level), 64'(1));
        check("early_rise_underflow", 64'(underflow), 64'(0));
        frame(1'b0, 1'b0);

        // Reference pattern.
        try_push(24'hA5A5A5, 24'h3C3C3C);
        frame(1'b0, 1'b0);

        // Empty FIFO frames.
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b0);

        // Fill to full; the fifth write must be dropped.
        vecs[0] = '{24'h000001, 24'h800000, LW'(1), 1'b1};
        vecs[1] = '{24'hFFFFFF, 24'h7FFFFF, LW'(2), 1'b1};
        vecs[2] = '{24'h0F1E2D, 24'hF0E1D2, LW'(3), 1'b1};
        vecs[3] = '{24'hAAAAAA, 24'h555555, LW'(4), 1'b0};
        vecs[4] = '{24'hDEAD00, 24'h00BEEF, LW'(4), 1'b0};
        for (int i = 0; i < 5; i++) begin
            try_push(vecs[i].l, vecs[i].r);
            check("vec_level", 64'(fifo_level), 64'(vecs[i].exp_level));
            check("vec_ready", 64'(write_ready), 64'(vecs[i].exp_ready));
        end
        for (int i = 0; i < 4; i++)
            frame(1'b0, 1'b0);

        // Push coincident with pop: empty, then non-empty.
        coincident_frame(24'h13579B, 24'h2468AC);
        coincident_frame(24'hC0FFEE, 24'hBADA55);
        frame(1'b0, 1'b0);

        // Write held high while frames run.
        cl              = 24'hC3A5FF;
        cr              = 24'h5A5A01;
        write           = 1'b1;
        writedata_left  = cl;
        writedata_right = cr;
        repeat (6) @(negedge CLOCK_50);
        for (int i = 0; i < DEPTH; i++) begin
            ql.push_back(cl);
            qr.push_back(cr);
        end
        mon_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame(1'b0, 1'b1);
            check("cont_ready", 64'(write_ready), 64'(0));
        end
        write  = 1'b0;
        mon_on = 1'b0;
        check("cont_never_over", 64'(over_cnt), 64'(0));

        // Reset in the middle of a left word with two pairs queued.
        frame(1'b0, 1'b0);
        AUD_DACLRCK = 1'b0;
        void'(ql.pop_front());
        void'(qr.pop_front());
        for (int i = 0; i < 8; i++)
            bclk_cycle(1'b0, b);
        check("mid_level", 64'(fifo_level), 64'(2));
        check("mid_bit", 64'(AUD_DACDAT), 64'(1));
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        ql.delete();
        qr.delete();
        m_under = 1'b0;
        check("mrst_level", 64'(fifo_level), 64'(0));
        check("mrst_dacdat", 64'(AUD_DACDAT), 64'(0));
        check("mrst_underflow", 64'(underflow), 64'(0));
        check("mrst_ready", 64'(write_ready), 64'(1));
        idle_bclks(40, any_one);
        check("mrst_silent", 64'(any_one), 64'(0));
        AUD_DACLRCK = 1'b1;
        idle_bclks(4, any_one);
        check("mrst_rise_silent", 64'(any_one), 64'(0));
        check("mrst_rise_underflow", 64'(underflow), 64'(0));
        frame(1'b0, 1'b0);
        try_push(24'h876543, 24'h345678);
        frame(1'b0, 1'b0);

        // Randomised pushes sprinkled through running frames.
        for (int i = 0; i < 6; i++)
            frame(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
